// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubbling
// and a saturating count of inserted bubbles.
module id_ex_latch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ctlwb_in,
    input  logic [2:0]  ctlm_in,
    input  logic [3:0]  ctlex_in,
    input  logic [31:0] npc_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [31:0] sext_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic        valid_in,
    input  logic        flush,
    output logic [1:0]  ctlwb_out,
    output logic [2:0]  ctlm_out,
    output logic [3:0]  ctlex_out,
    output logic [31:0] npc_out,
    output logic [31:0] rd1_out,
    output logic [31:0] rd2_out,
    output logic [31:0] sext_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic        valid_out,
    output logic        stall_out,
    output logic [15:0] bubble_cnt
);

    logic [1:0]  ctlwb_q, ctlwb_d;
    logic [2:0]  ctlm_q, ctlm_d;
    logic [3:0]  ctlex_q, ctlex_d;
    logic [31:0] npc_q, rd1_q, rd2_q, sext_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard_s;
    logic        bubble_s;

    // A load in EX whose destination feeds the ID instruction; $zero never conflicts.
    assign hazard_s = valid_q & ctlm_q[1] & valid_in & (rt_q != 5'd0)
                    & ((rt_q == rs_in) | (rt_q == rt_in));
    assign bubble_s  = flush | hazard_s;
    assign stall_out = hazard_s & ~flush;

    // Next-state selection for control fields, valid bit and bubble counter
    always_comb begin
        ctlwb_d = 2'd0;
        ctlm_d  = 3'd0;
        ctlex_d = 4'd0;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (bubble_s) begin
            ctlwb_d = 2'd0;
            ctlm_d  = 3'd0;
            ctlex_d = 4'd0;
            valid_d = 1'b0;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (valid_in) begin
            ctlwb_d = ctlwb_in;
            ctlm_d  = ctlm_in;
            ctlex_d = ctlex_in;
            valid_d = 1'b1;
        end else begin
            ctlwb_d = 2'd0;
            ctlm_d  = 3'd0;
            ctlex_d = 4'd0;
            valid_d = 1'b0;
        end
    end

    // Pipeline register: data fields always follow inputs, even during a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctlwb_q <= 2'd0;
            ctlm_q  <= 3'd0;
            ctlex_q <= 4'd0;
            npc_q   <= 32'd0;
            rd1_q   <= 32'd0;
            rd2_q   <= 32'd0;
            sext_q  <= 32'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            rd_q    <= 5'd0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            ctlwb_q <= ctlwb_d;
            ctlm_q  <= ctlm_d;
            ctlex_q <= ctlex_d;
            npc_q   <= npc_in;
            rd1_q   <= rd1_in;
            rd2_q   <= rd2_in;
            sext_q  <= sext_in;
            rs_q    <= rs_in;
            rt_q    <= rt_in;
            rd_q    <= rd_in;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctlwb_out  = ctlwb_q;
    assign ctlm_out   = ctlm_q;
    assign ctlex_out  = ctlex_q;
    assign npc_out    = npc_q;
    assign rd1_out    = rd1_q;
    assign rd2_out    = rd2_q;
    assign sext_out   = sext_q;
    assign rs_out     = rs_q;
    assign rt_out     = rt_q;
    assign rd_out     = rd_q;
    assign valid_out  = valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: expected outputs are queued when a step is driven
// and compared one edge later; stall_out is checked in the same cycle.
module tb_id_ex_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctlwb_in;
    logic [2:0]  ctlm_in;
    logic [3:0]  ctlex_in;
    logic [31:0] npc_in, rd1_in, rd2_in, sext_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        valid_in, flush;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [3:0]  ctlex_out;
    logic [31:0] npc_out, rd1_out, rd2_out, sext_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        valid_out, stall_out;
    logic [15:0] bubble_cnt;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sext;
        logic [4:0]  rs, rt, rd;
        logic        v;
        logic [15:0] cnt;
    } out_t;

    out_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference state of the stage as seen from the outputs
    logic        m_v;
    logic [2:0]  m_m;
    logic [4:0]  m_rt;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    id_ex_latch dut (
        .clk(clk), .rst_n(rst_n),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
        .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .sext_in(sext_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .valid_in(valid_in), .flush(flush),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
        .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .sext_out(sext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .valid_out(valid_out), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
    );

    function automatic out_t observed();
        out_t o;
        o = {ctlwb_out, ctlm_out, ctlex_out, npc_out, rd1_out, rd2_out, sext_out,
             rs_out, rt_out, rd_out, valid_out, bubble_cnt};
        return o;
    endfunction

    task automatic check_stall(input logic exp, input string tag);
        total++;
        assert (stall_out === exp) else begin
            bad++;
            $error("FAIL %s stall_out got=%0b exp=%0b", tag, stall_out, exp);
        end
    endtask

    task automatic check_out(input out_t exp, input string tag);
        out_t obs;
        obs = observed();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s outputs got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_m = 3'd0; m_rt = 5'd0; m_cnt = 16'd0;
        sb.delete();
    endtask

    // Drive one ID slot, check stall in-cycle, then check the registered result
    task automatic step(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                        input logic [31:0] npc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] sx, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic v, input logic fl, input string tag);
        logic haz, bub;
        out_t e;
        @(negedge clk);
        ctlwb_in = wb; ctlm_in = m; ctlex_in = ex; npc_in = npc; rd1_in = r1; rd2_in = r2;
        sext_in = sx; rs_in = rs; rt_in = rt; rd_in = rd; valid_in = v; flush = fl;
        #1;
        haz = m_v && m_m[1] && v && (m_rt != 5'd0) && ((m_rt == rs) || (m_rt == rt));
        bub = fl || haz;
        check_stall(haz && !fl, tag);
        e.npc = npc; e.rd1 = r1; e.rd2 = r2; e.sext = sx; e.rs = rs; e.rt = rt; e.rd = rd;
        if (!bub && v) begin
            e.wb = wb; e.m = m; e.ex = ex; e.v = 1'b1;
        end else begin
            e.wb = 2'd0; e.m = 3'd0; e.ex = 4'd0; e.v = 1'b0;
        end
        e.cnt = (bub && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
        sb.push_back(e);
        m_v = e.v; m_m = e.m; m_rt = rt; m_cnt = e.cnt;
        @(posedge clk);
        #1;
        check_out(sb.pop_front(), tag);
    endtask

    initial begin
        out_t zero;
        zero = '0;
        rst_n = 1'b0;
        ctlwb_in = 2'd0; ctlm_in = 3'd0; ctlex_in = 4'd0; npc_in = 32'd0; rd1_in = 32'd0;
        rd2_in = 32'd0; sext_in = 32'd0; rs_in = 5'd0; rt_in = 5'd0; rd_in = 5'd0;
        valid_in = 1'b1; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out(zero, "reset_outs");
        check_stall(1'b0, "reset_stall");
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through of a valid instruction
        step(2'b10, 3'b000, 4'b1100, 32'h0000_0104, 32'h1111_2222, 32'h3333_4444,
             32'hFFFF_FFF6, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, "pass");
        total++;
        assert (bubble_cnt === 16'd0) else begin
            bad++;
            $error("FAIL pass_cnt got=%0d exp=0", bubble_cnt);
        end

        // Load-use: lw rt=8 then consumer rs=8, then the stall must drop
        step(2'b11, 3'b010, 4'b0001, 32'h108, 32'hA, 32'hB, 32'h10, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, "lu_lw");
        step(2'b10, 3'b000, 4'b1100, 32'h10C, 32'hC, 32'hD, 32'h0, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, "lu_stall");
        step(2'b10, 3'b000, 4'b1100, 32'h10C, 32'hC, 32'hD, 32'h0, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, "lu_retry");
        total++;
        assert (bubble_cnt === 16'd1) else begin
            bad++;
            $error("FAIL lu_cnt got=%0d exp=1", bubble_cnt);
        end

        // Load into $zero never stalls; neither does an invalid consumer
        step(2'b11, 3'b010, 4'b0001, 32'h200, 32'h1, 32'h2, 32'h4, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, "z_lw");
        step(2'b10, 3'b000, 4'b1100, 32'h204, 32'h1, 32'h2, 32'h4, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, "z_use");
        step(2'b11, 3'b010, 4'b0001, 32'h208, 32'h1, 32'h2, 32'h4, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, "inv_lw");
        step(2'b00, 3'b001, 4'b0001, 32'h20C, 32'h1, 32'h2, 32'h4, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, "inv_sw");
        // Consumer of rt (not rs) after a load also stalls
        step(2'b11, 3'b010, 4'b0001, 32'h210, 32'h1, 32'h2, 32'h4, 5'd3, 5'd12, 5'd0, 1'b1, 1'b0, "rt_lw");
        step(2'b10, 3'b000, 4'b1100, 32'h214, 32'h5, 32'h6, 32'h0, 5'd1, 5'd12, 5'd2, 1'b1, 1'b0, "rt_use");

        // Flush together with a hazard: one bubble, no stall
        step(2'b11, 3'b010, 4'b0001, 32'h300, 32'h1, 32'h2, 32'h4, 5'd3, 5'd5, 5'd0, 1'b1, 1'b0, "fh_lw");
        step(2'b10, 3'b000, 4'b1100, 32'h304, 32'h1, 32'h2, 32'h4, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, "fh_both");

        // Mixed non-load traffic
        for (int i = 0; i < 6; i++) begin
            step(2'($urandom), 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 1)), 4'($urandom),
                 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), 1'($urandom), 1'b0, "mix");
        end

        // Saturation of the bubble counter
        for (int i = 0; i < 65540; i++) begin
            step(2'b11, 3'b111, 4'b1111, 32'(i), 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, "sat");
        end
        total++;
        assert (bubble_cnt === 16'hFFFF) else begin
            bad++;
            $error("FAIL sat_cnt got=%h exp=ffff", bubble_cnt);
        end

        // Asynchronous reset asserted between edges while stalling
        step(2'b11, 3'b010, 4'b0001, 32'h400, 32'h1, 32'h2, 32'h4, 5'd3, 5'd7, 5'd0, 1'b1, 1'b0, "ar_lw");
        @(negedge clk);
        rs_in = 5'd7; rt_in = 5'd9; ctlm_in = 3'd0; valid_in = 1'b1; flush = 1'b0;
        #1;
        check_stall(1'b1, "ar_pre");
        #1;
        rst_n = 1'b0;
        #1;
        check_out(zero, "ar_outs");
        check_stall(1'b0, "ar_stall");
        model_reset();
        @(posedge clk);
        #1;
        check_out(zero, "ar_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 3'b100, 4'b0010, 32'h500, 32'h7, 32'h8, 32'h9, 5'd7, 5'd9, 5'd11, 1'b1, 1'b0, "ar_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
